i2c_scl_gen: RTL and testbench

I2C_SCL_GEN -- requirements
Module: i2c_scl_gen

---
 rtl/i2c_pkg.sv | 14 +
 rtl/i2c_scl_gen.sv | 106 ++++++++++
 tb/tb_i2c_scl_gen.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and divisor limit for the I2C SCL generator
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOW     = 2'd1,
    ST_HIGH    = 2'd2,
    ST_STRETCH = 2'd3
  } state_t;

  // Smallest half-period that still keeps the four phase pulses in distinct cycles.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/i2c_scl_gen.sv
// rtl/i2c_scl_gen.sv - I2C SCL clock generator with clock-stretch detection
// and registered phase pulses.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DIV_DEF = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             scl_in,
  output logic             scl_out,
  output logic             scl_fall_p,
  output logic             scl_rise_p,
  output logic             mid_low_p,
  output logic             mid_high_p,
  output logic             stretch,
  output logic             busy
);

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] d, d_n;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (div_val >= DIV_W'(MIN_DIV)) ? div_val : DIV_W'(DIV_DEF);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_n     = d;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (en) begin
          state_n = ST_LOW;
          d_n     = div_eff;
        end
      end
      ST_LOW: begin
        if (cnt == d - DIV_W'(1)) begin
          state_n = ST_HIGH;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      ST_HIGH: begin
        // A slave holding SCL low is only recognised in the first high cycle.
        if (!scl_in && cnt == '0) begin
          state_n = ST_STRETCH;
        end else if (cnt == d - DIV_W'(1)) begin
          cnt_n = '0;
          if (en) begin
            state_n = ST_LOW;
            d_n     = div_eff;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      ST_STRETCH: begin
        if (scl_in) begin
          state_n = ST_HIGH;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are derived from the next-state values so they line up with the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      d          <= DIV_W'(DIV_DEF);
      scl_out    <= 1'b1;
      scl_fall_p <= 1'b0;
      scl_rise_p <= 1'b0;
      mid_low_p  <= 1'b0;
      mid_high_p <= 1'b0;
      stretch    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      d          <= d_n;
      scl_out    <= (state_n != ST_LOW);
      scl_fall_p <= (state_n == ST_LOW) && (state != ST_LOW);
      scl_rise_p <= (state_n == ST_HIGH) && (state == ST_LOW);
      mid_low_p  <= (state_n == ST_LOW) && (cnt_n == (d_n >> 1));
      mid_high_p <= (state_n == ST_HIGH) && (cnt_n == (d_n >> 1));
      stretch    <= (state_n == ST_STRETCH);
      busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// tb/tb_i2c_scl_gen.sv - table-driven and directed checks for i2c_scl_gen
module tb_i2c_scl_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       hold;
  logic [7:0] div_val;
  logic       scl_in;
  logic       scl_out, scl_fall_p, scl_rise_p, mid_low_p, mid_high_p, stretch, busy;

  int checks = 0;
  int errors = 0;

  i2c_scl_gen #(.DIV_W(8), .DIV_DEF(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_val    (div_val),
    .scl_in     (scl_in),
    .scl_out    (scl_out),
    .scl_fall_p (scl_fall_p),
    .scl_rise_p (scl_rise_p),
    .mid_low_p  (mid_low_p),
    .mid_high_p (mid_high_p),
    .stretch    (stretch),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // The line follows our own drive unless the bench plays a stretching slave.
  assign scl_in = hold ? 1'b0 : scl_out;

  // Expected vector order: {scl_out, fall, rise, mid_low, mid_high, stretch, busy}
  typedef struct {
    logic       en;
    logic [7:0] div;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] outs();
    return {scl_out, scl_fall_p, scl_rise_p, mid_low_p, mid_high_p, stretch, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    hold = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Steps until the next fall pulse; positions are counted from the previous fall.
  task automatic period(input int limit, output int n, output int ml, output int mh, output int rs);
    n  = -1;
    ml = -1;
    mh = -1;
    rs = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (mid_low_p && ml < 0) ml = i;
      if (mid_high_p && mh < 0) mh = i;
      if (scl_rise_p && rs < 0) rs = i;
      if (scl_fall_p) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, ml, mh, rs, st;

    tbl.push_back('{1'b1, 8'd4, 7'b0100001});
    tbl.push_back('{1'b1, 8'd4, 7'b0000001});
    tbl.push_back('{1'b1, 8'd4, 7'b0001001});
    tbl.push_back('{1'b1, 8'd4, 7'b0000001});
    tbl.push_back('{1'b1, 8'd4, 7'b1010001});
    tbl.push_back('{1'b1, 8'd4, 7'b1000001});
    tbl.push_back('{1'b1, 8'd4, 7'b1000101});
    tbl.push_back('{1'b1, 8'd4, 7'b1000001});
    tbl.push_back('{1'b1, 8'd4, 7'b0100001});
    tbl.push_back('{1'b1, 8'd4, 7'b0000001});
    tbl.push_back('{1'b0, 8'd4, 7'b0001001});
    tbl.push_back('{1'b0, 8'd4, 7'b0000001});
    tbl.push_back('{1'b0, 8'd4, 7'b1010001});
    tbl.push_back('{1'b0, 8'd4, 7'b1000001});
    tbl.push_back('{1'b0, 8'd4, 7'b1000101});
    tbl.push_back('{1'b0, 8'd4, 7'b1000001});
    tbl.push_back('{1'b0, 8'd4, 7'b1000000});
    tbl.push_back('{1'b0, 8'd4, 7'b1000000});
    tbl.push_back('{1'b1, 8'd4, 7'b0100001});
    tbl.push_back('{1'b1, 8'd4, 7'b0000001});
    tbl.push_back('{1'b1, 8'd4, 7'b0001001});
    tbl.push_back('{1'b1, 8'd4, 7'b0000001});
    tbl.push_back('{1'b1, 8'd4, 7'b1010001});
    tbl.push_back('{1'b1, 8'd6, 7'b1000001});
    tbl.push_back('{1'b1, 8'd6, 7'b1000101});
    tbl.push_back('{1'b1, 8'd6, 7'b1000001});
    tbl.push_back('{1'b1, 8'd6, 7'b0100001});
    tbl.push_back('{1'b1, 8'd6, 7'b0000001});
    tbl.push_back('{1'b1, 8'd6, 7'b0000001});
    tbl.push_back('{1'b1, 8'd6, 7'b0001001});
    tbl.push_back('{1'b1, 8'd6, 7'b0000001});
    tbl.push_back('{1'b1, 8'd6, 7'b0000001});
    tbl.push_back('{1'b1, 8'd6, 7'b1010001});
    tbl.push_back('{1'b1, 8'd6, 7'b1000001});
    tbl.push_back('{1'b1, 8'd6, 7'b1000001});
    tbl.push_back('{1'b1, 8'd6, 7'b1000101});
    tbl.push_back('{1'b1, 8'd6, 7'b1000001});
    tbl.push_back('{1'b1, 8'd6, 7'b1000001});
    tbl.push_back('{1'b1, 8'd6, 7'b0100001});

    rst     = 1'b1;
    en      = 1'b0;
    hold    = 1'b0;
    div_val = 8'd4;
    step();
    step();
    check("reset_outputs", outs(), 7'b1000000);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      en      = tbl[i].en;
      div_val = tbl[i].div;
      step();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Divisors below the minimum fall back to the default of 8.
    do_reset();
    div_val = 8'd1;
    en      = 1'b1;
    step();
    check("def_first_fall", outs(), 7'b0100001);
    div_val = 8'd0;
    period(100, n, ml, mh, rs);
    check("def_period_div1", n, 16);
    check("def_mid_low", ml, 4);
    check("def_rise", rs, 8);
    check("def_mid_high", mh, 12);
    period(100, n, ml, mh, rs);
    check("def_period_div0", n, 16);

    // Slave stretches the high phase for 10 cycles.
    do_reset();
    div_val = 8'd4;
    en      = 1'b1;
    step();
    check("str_first_fall", scl_fall_p, 1);
    for (int i = 0; i < 4; i++) step();
    check("str_rise", scl_rise_p, 1);
    hold = 1'b1;
    st   = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (stretch) st++;
    end
    check("stretch_cycles", st, 10);
    check("stretch_released", {scl_out, busy}, 2'b11);
    hold = 1'b0;
    period(100, n, ml, mh, rs);
    check("stretch_period", 14 + n, 19);
    check("stretch_mid_high", mh, 3);

    // Asynchronous reset in the middle of the low phase.
    do_reset();
    div_val = 8'd4;
    en      = 1'b1;
    step();
    step();
    step();
    check("pre_rst_low", outs(), 7'b0001001);
    rst = 1'b1;
    #1;
    check("rst_async", outs(), 7'b1000000);
    step();
    check("rst_held", outs(), 7'b1000000);
    rst = 1'b0;
    step();
    check("rst_release_fall", outs(), 7'b0100001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
